// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_cfg
// Purpose  : Configurable asynchronous serial receiver. The data width, the
//            parity mode and the number of stop bits are set at elaboration.
//            Each bit is decided by a 3-sample majority vote around the bit
//            centre. Each character is reported with framing-error,
//            parity-error and line-break flags.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CLKS_PER_BIT  clock cycles per bit (Clock freq / baud), >= 8
//   DATA_BITS     data bits per character, 5..9
//   PARITY        0 = none, 1 = odd, 2 = even
//   STOP_BITS     stop bits checked, 1 or 2
// Ports
//   Clock          in   system clock
//   reset          in   synchronous, active-high reset
//   Rx_Serial      in   asynchronous serial line, idle high
//   Rx_DV          out  one-cycle pulse: character complete, data/flags valid
//   Rx_Data        out  received character (LSB first on the line)
//   Rx_Frame_Err   out  a stop bit was sampled 0
//   Rx_Parity_Err  out  parity mismatch (always 0 without parity)
//   Rx_Break       out  line held low for the whole frame
// ============================================================================
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 100,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 Clock,
    input  logic                 reset,
    input  logic                 Rx_Serial,
    output logic                 Rx_DV,
    output logic [DATA_BITS-1:0] Rx_Data,
    output logic                 Rx_Frame_Err,
    output logic                 Rx_Parity_Err,
    output logic                 Rx_Break
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    if (CLKS_PER_BIT < 8) begin : g_bad_clks_per_bit
        $error("uart_rx_cfg: CLKS_PER_BIT must be >= 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_cfg: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int H  = (CLKS_PER_BIT - 1) / 2;
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_EARLY = CW'(H - 1);
    localparam logic [CW-1:0] CNT_MID   = CW'(H);
    localparam logic [CW-1:0] CNT_DEC   = CW'(H + 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        PARITY_BIT = 3'd3,
        STOP       = 3'd4,
        DONE       = 3'd5,
        WAIT_HIGH  = 3'd6
    } state_t;

    // ------------------------------------------------------------------------
    // Two-flop synchronizer. Both flops reset to the idle (high) level, so
    // the release of reset cannot look like a start edge.
    // ------------------------------------------------------------------------
    logic sync_meta;
    logic sync_line;

    always_ff @(posedge Clock) begin
        if (reset) begin
            sync_meta <= 1'b1;
            sync_line <= 1'b1;
        end else begin
            sync_meta <= Rx_Serial;
            sync_line <= sync_meta;
        end
    end

    // ------------------------------------------------------------------------
    // Receiver state
    // ------------------------------------------------------------------------
    state_t               state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 samp_early;
    logic                 samp_mid;
    logic                 par_bit;
    logic                 par_err;
    logic                 frame_err;
    logic                 stop1_val;

    // Majority of the samples at H-1 and H and the live line at H+1. This
    // is only used at count H+1.
    logic vote;
    assign vote = (samp_early & samp_mid) | (samp_early & sync_line) |
                  (samp_mid & sync_line);

    // Value of the first stop bit, used by break detection. With one stop
    // bit it is the bit being decided now.
    logic first_stop;
    assign first_stop = (STOP_BITS == 1) ? vote : stop1_val;

    // A bit is complete when the counter wraps. The counter never passes
    // CLKS_PER_BIT-1.
    logic [CW-1:0] cnt_next;
    assign cnt_next = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);

    always_ff @(posedge Clock) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            stop_idx      <= 1'b0;
            shreg         <= '0;
            samp_early    <= 1'b0;
            samp_mid      <= 1'b0;
            par_bit       <= 1'b0;
            par_err       <= 1'b0;
            frame_err     <= 1'b0;
            stop1_val     <= 1'b1;
            Rx_DV         <= 1'b0;
            Rx_Data       <= '0;
            Rx_Frame_Err  <= 1'b0;
            Rx_Parity_Err <= 1'b0;
            Rx_Break      <= 1'b0;
        end else begin
            Rx_DV <= 1'b0;

            if (cnt == CNT_EARLY) begin
                samp_early <= sync_line;
            end
            if (cnt == CNT_MID) begin
                samp_mid <= sync_line;
            end

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!sync_line) begin
                        state     <= START;
                        bit_idx   <= '0;
                        stop_idx  <= 1'b0;
                        par_bit   <= 1'b0;
                        par_err   <= 1'b0;
                        frame_err <= 1'b0;
                        stop1_val <= 1'b1;
                    end
                end

                START: begin
                    if (cnt == CNT_DEC && vote) begin
                        // The low pulse did not last to mid-bit: treat it
                        // as noise.
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_next;
                        if (cnt == CNT_LAST) begin
                            state <= DATA;
                        end
                    end
                end

                DATA: begin
                    if (cnt == CNT_DEC) begin
                        shreg <= {vote, shreg[DATA_BITS-1:1]};
                    end
                    cnt <= cnt_next;
                    if (cnt == CNT_LAST) begin
                        if (bit_idx == IDX_LAST) begin
                            state <= (PARITY != 0) ? PARITY_BIT : STOP;
                        end else begin
                            bit_idx <= bit_idx + IW'(1);
                        end
                    end
                end

                PARITY_BIT: begin
                    if (cnt == CNT_DEC) begin
                        par_bit <= vote;
                        // XOR over data and parity is 1 for an odd count
                        // of ones.
                        par_err <= (PARITY == 1) ? ~(^{shreg, vote})
                                                 : (^{shreg, vote});
                    end
                    cnt <= cnt_next;
                    if (cnt == CNT_LAST) begin
                        state <= STOP;
                    end
                end

                STOP: begin
                    if (cnt == CNT_DEC) begin
                        if (!vote) begin
                            frame_err <= 1'b1;
                        end
                        if (STOP_BITS == 1 || stop_idx) begin
                            // On the final stop bit, report right away. The
                            // rest of the bit is left for IDLE so that a
                            // back-to-back start edge is not missed.
                            state         <= DONE;
                            cnt           <= '0;
                            Rx_DV         <= 1'b1;
                            Rx_Data       <= shreg;
                            Rx_Frame_Err  <= frame_err | ~vote;
                            Rx_Parity_Err <= par_err;
                            Rx_Break      <= (shreg == '0) &&
                                             ((PARITY == 0) || !par_bit) &&
                                             !first_stop;
                        end else begin
                            stop1_val <= vote;
                            cnt       <= cnt_next;
                        end
                    end else begin
                        cnt <= cnt_next;
                        if (cnt == CNT_LAST) begin
                            stop_idx <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    cnt <= '0;
                    // A line that is still low after a framing error is a
                    // break or a stuck line. Wait for it to go high instead
                    // of taking it as a new start bit.
                    if (!sync_line && Rx_Frame_Err) begin
                        state <= WAIT_HIGH;
                    end else begin
                        state <= IDLE;
                    end
                end

                WAIT_HIGH: begin
                    cnt <= '0;
                    if (sync_line) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_cfg
// Purpose  : Self-checking bench for uart_rx_cfg. It drives three
//            configurations (8N1, 7E1 and 8N2) at 16 clocks per bit. Each
//            expected character goes into a per-channel queue when its frame
//            is driven, and is compared when that receiver pulses Rx_DV.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_cfg;

    localparam int CPB = 16;
    localparam int H   = (CPB - 1) / 2;

    logic       Clock = 1'b0;
    logic       reset = 1'b1;
    logic       rx_a  = 1'b1;
    logic       rx_b  = 1'b1;
    logic       rx_c  = 1'b1;

    logic       dv_a, fe_a, pe_a, brk_a;
    logic [7:0] data_a;
    logic       dv_b, fe_b, pe_b, brk_b;
    logic [6:0] data_b;
    logic       dv_c, fe_c, pe_c, brk_c;
    logic [7:0] data_c;

    always #5 Clock = ~Clock;

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .Clock(Clock), .reset(reset), .Rx_Serial(rx_a), .Rx_DV(dv_a), .Rx_Data(data_a),
        .Rx_Frame_Err(fe_a), .Rx_Parity_Err(pe_a), .Rx_Break(brk_a));

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_7e1 (
        .Clock(Clock), .reset(reset), .Rx_Serial(rx_b), .Rx_DV(dv_b), .Rx_Data(data_b),
        .Rx_Frame_Err(fe_b), .Rx_Parity_Err(pe_b), .Rx_Break(brk_b));

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
        .Clock(Clock), .reset(reset), .Rx_Serial(rx_c), .Rx_DV(dv_c), .Rx_Data(data_c),
        .Rx_Frame_Err(fe_c), .Rx_Parity_Err(pe_c), .Rx_Break(brk_c));

    typedef struct packed {
        logic [8:0] data;
        logic       fe;
        logic       pe;
        logic       brk;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    exp_t last_exp[3];
    bit   prev_dv[3];
    int   stop_cyc[3];
    int   dv_cyc[3];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    always @(posedge Clock) cyc++;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int qsize(input int ch);
        case (ch)
            0:       return q_a.size();
            1:       return q_b.size();
            default: return q_c.size();
        endcase
    endfunction

    task automatic expect_frame(input int ch, input logic [8:0] d, input logic fe,
                                input logic pe, input logic brk);
        exp_t e;
        e = '{data: d, fe: fe, pe: pe, brk: brk};
        case (ch)
            0:       q_a.push_back(e);
            1:       q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
    endtask

    // Scoreboard side: called once per channel on every falling edge.
    task automatic score(input int ch, input logic dv, input logic [8:0] d,
                         input logic fe, input logic pe, input logic brk);
        exp_t  e;
        string nm;
        nm = (ch == 0) ? "8n1" : (ch == 1) ? "7e1" : "8n2";
        if (prev_dv[ch]) begin
            check_val({nm, "_dv_width"}, 32'(dv), 32'd0);
            check_val({nm, "_hold"}, 32'({d, fe, pe, brk}), 32'(last_exp[ch]));
        end
        prev_dv[ch] = (dv === 1'b1);
        if (dv === 1'b1) begin
            dv_cyc[ch] = cyc;
            check_val({nm, "_dv_expected"}, 32'(qsize(ch) > 0), 32'd1);
            if (qsize(ch) > 0) begin
                case (ch)
                    0:       e = q_a.pop_front();
                    1:       e = q_b.pop_front();
                    default: e = q_c.pop_front();
                endcase
                last_exp[ch] = e;
                check_val({nm, "_data"}, 32'(d), 32'(e.data));
                check_val({nm, "_flags_fe_pe_brk"}, 32'({fe, pe, brk}), 32'({e.fe, e.pe, e.brk}));
            end
        end
    endtask

    always @(negedge Clock) begin
        score(0, dv_a, {1'b0, data_a}, fe_a, pe_a, brk_a);
        score(1, dv_b, {2'b0, data_b}, fe_b, pe_b, brk_b);
        score(2, dv_c, {1'b0, data_c}, fe_c, pe_c, brk_c);
    end

    // Stimulus side: every task below is entered and left on a falling edge.
    task automatic set_line(input int ch, input logic v);
        case (ch)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    task automatic drive_bit(input int ch, input logic v, input int n);
        set_line(ch, v);
        repeat (n) @(negedge Clock);
    endtask

    // The stop bits are 1 followed by last_stop when nstop is 2, or only
    // last_stop when nstop is 1. noise_bit selects a data bit that gets a
    // one-cycle inversion landing on receiver count H.
    task automatic send_frame(input int ch, input logic [8:0] d, input int nbits,
                              input bit has_par, input logic pbit, input int nstop,
                              input logic last_stop, input int noise_bit);
        drive_bit(ch, 1'b0, CPB);
        for (int i = 0; i < nbits; i++) begin
            if (i == noise_bit) begin
                drive_bit(ch, d[i], H + 1);
                drive_bit(ch, ~d[i], 1);
                drive_bit(ch, d[i], CPB - H - 2);
            end else begin
                drive_bit(ch, d[i], CPB);
            end
        end
        if (has_par) drive_bit(ch, pbit, CPB);
        if (nstop == 2) drive_bit(ch, 1'b1, CPB);
        // The first rising edge that samples the final stop bit.
        stop_cyc[ch] = cyc + 1;
        drive_bit(ch, last_stop, CPB);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] d7;
        reset = 1'b1;
        repeat (4) @(negedge Clock);
        reset = 1'b0;
        @(negedge Clock);

        // Reset state
        check_val("rst_8n1_outputs", 32'({dv_a, data_a, fe_a, pe_a, brk_a}), 32'd0);
        check_val("rst_7e1_outputs", 32'({dv_b, data_b, fe_b, pe_b, brk_b}), 32'd0);
        check_val("rst_8n2_outputs", 32'({dv_c, data_c, fe_c, pe_c, brk_c}), 32'd0);
        repeat (CPB) @(negedge Clock);

        // 8N1 0xA5 with latency measurement
        expect_frame(0, 9'h0A5, 1'b0, 1'b0, 1'b0);
        send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1, -1);
        check_val("8n1_latency", 32'(dv_cyc[0] - stop_cyc[0]), 32'(H + 4));
        repeat (2 * CPB) @(negedge Clock);

        // 7E1: a correct parity bit, a forced-wrong parity bit, then an
        // odd-weight character with its correct parity bit
        d7 = 7'h35;
        expect_frame(1, 9'h035, 1'b0, 1'b0, 1'b0);
        send_frame(1, {2'b0, d7}, 7, 1'b1, ^d7, 1, 1'b1, -1);
        repeat (CPB) @(negedge Clock);
        expect_frame(1, 9'h035, 1'b0, 1'b1, 1'b0);
        send_frame(1, {2'b0, d7}, 7, 1'b1, 1'b1, 1, 1'b1, -1);
        repeat (CPB) @(negedge Clock);
        d7 = 7'h01;
        expect_frame(1, 9'h001, 1'b0, 1'b0, 1'b0);
        send_frame(1, {2'b0, d7}, 7, 1'b1, ^d7, 1, 1'b1, -1);
        repeat (2 * CPB) @(negedge Clock);

        // 8N2: second stop bit low, then a clean frame
        expect_frame(2, 9'h03C, 1'b1, 1'b0, 1'b0);
        send_frame(2, 9'h03C, 8, 1'b0, 1'b0, 2, 1'b0, -1);
        set_line(2, 1'b1);
        repeat (2 * CPB) @(negedge Clock);
        expect_frame(2, 9'h055, 1'b0, 1'b0, 1'b0);
        send_frame(2, 9'h055, 8, 1'b0, 1'b0, 2, 1'b1, -1);
        repeat (2 * CPB) @(negedge Clock);

        // 8N1 line held low for three frame times: a single break
        // character, then a clean frame once the line is released
        expect_frame(0, 9'h000, 1'b1, 1'b0, 1'b1);
        drive_bit(0, 1'b0, 3 * 10 * CPB);
        drive_bit(0, 1'b1, 2 * CPB);
        expect_frame(0, 9'h0C3, 1'b0, 1'b0, 1'b0);
        send_frame(0, 9'h0C3, 8, 1'b0, 1'b0, 1, 1'b1, -1);
        repeat (2 * CPB) @(negedge Clock);

        // 8N1 start glitch (no character), then noisy data bits
        drive_bit(0, 1'b0, 3);
        drive_bit(0, 1'b1, 2 * CPB);
        expect_frame(0, 9'h081, 1'b0, 1'b0, 1'b0);
        send_frame(0, 9'h081, 8, 1'b0, 1'b0, 1, 1'b1, 3);
        repeat (CPB) @(negedge Clock);
        expect_frame(0, 9'h081, 1'b0, 1'b0, 1'b0);
        send_frame(0, 9'h081, 8, 1'b0, 1'b0, 1, 1'b1, 7);
        repeat (2 * CPB) @(negedge Clock);

        // 8N1 back-to-back frames, then reset in the middle of a third frame
        expect_frame(0, 9'h012, 1'b0, 1'b0, 1'b0);
        expect_frame(0, 9'h034, 1'b0, 1'b0, 1'b0);
        send_frame(0, 9'h012, 8, 1'b0, 1'b0, 1, 1'b1, -1);
        send_frame(0, 9'h034, 8, 1'b0, 1'b0, 1, 1'b1, -1);
        check_val("8n1_b2b_latency", 32'(dv_cyc[0] - stop_cyc[0]), 32'(H + 4));
        drive_bit(0, 1'b0, CPB);
        drive_bit(0, 1'b1, CPB);
        drive_bit(0, 1'b0, CPB);
        drive_bit(0, 1'b0, CPB / 2);
        reset = 1'b1;
        set_line(0, 1'b1);
        repeat (3) @(negedge Clock);
        reset = 1'b0;
        @(negedge Clock);
        check_val("midreset_8n1_outputs", 32'({dv_a, data_a, fe_a, pe_a, brk_a}), 32'd0);
        repeat (2 * CPB) @(negedge Clock);
        expect_frame(0, 9'h056, 1'b0, 1'b0, 1'b0);
        send_frame(0, 9'h056, 8, 1'b0, 1'b0, 1, 1'b1, -1);
        repeat (3 * CPB) @(negedge Clock);

        // Every expected character must have been delivered
        check_val("8n1_queue_drained", 32'(qsize(0)), 32'd0);
        check_val("7e1_queue_drained", 32'(qsize(1)), 32'd0);
        check_val("8n2_queue_drained", 32'(qsize(2)), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
